// File: rtl/mmio_sram_responder_pkg.sv
// mmio_sram_responder_pkg
//   Shared constants and types for the MMIO SRAM responder.
//   - MMIO_BASE_HI : default value of addr[31:16] that selects the block
//   - OFF_*        : word offsets (addr[15:0]) of each mapped register
//   - mmio_req_t   : decoded view of one SRAM-port request cycle
package mmio_sram_responder_pkg;

  localparam logic [15:0] MMIO_BASE_HI = 16'hbfaf;

  localparam logic [15:0] OFF_CR0    = 16'h0000;
  localparam logic [15:0] OFF_CR1    = 16'h0004;
  localparam logic [15:0] OFF_CR2    = 16'h0008;
  localparam logic [15:0] OFF_CR3    = 16'h000c;
  localparam logic [15:0] OFF_TIMER  = 16'he000;
  localparam logic [15:0] OFF_LED    = 16'hf020;
  localparam logic [15:0] OFF_SWITCH = 16'hf030;
  localparam logic [15:0] OFF_NUM    = 16'hf050;

  typedef struct packed {
    logic        hit;  // strobe and base match
    logic        rd;   // strobe with no byte enables (hit or miss)
    logic        wr;   // hit with at least one byte enable
    logic [15:0] off;  // word-aligned offset, addr[1:0] forced to 0
  } mmio_req_t;

endpackage

// File: rtl/mmio_sram_responder_timer.sv
// mmio_timer
//   Free-running 32-bit up-counter with byte-granular write port.
//   Only instantiated when MMIO_TIMER_EN is defined.
//   Ports:
//     clk, resetn  : clock, async active-low reset (counter clears to 0)
//     we_i[3:0]    : byte write mask, already qualified by the address decode
//     wdata_i      : write data
//     value_o      : current counter value (pre-increment for this cycle)
module mmio_timer (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] value_o
);

  logic [31:0] cnt_q, cnt_d, cnt_inc;

  // Written bytes take wdata as-is; the rest keep counting, so a partial
  // write never gets an extra +1 on top of the written lanes.
  always_comb begin
    cnt_inc = cnt_q + 32'd1;
    cnt_d   = cnt_inc;
    for (int b = 0; b < 4; b++)
      if (we_i[b]) cnt_d[8*b +: 8] = wdata_i[8*b +: 8];
  end

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;

  assign value_o = cnt_q;

endmodule

// File: rtl/mmio_sram_responder.sv
// mmio_sram_responder
//   Target side of the core's data SRAM port: a small register file of
//   scratch registers, LEDs, switches, a numeric display and (optionally)
//   a free-running timer. Read data is returned one cycle after the request.
//   Build option: define MMIO_TIMER_EN to include the timer at 0xe000;
//   otherwise that offset reads 0 and ignores writes.
//   Ports:
//     clk, resetn          : clock, async active-low reset
//     sram_en/we/addr/wdata: request from the core (we!=0 means write)
//     sram_rdata           : registered read data
//     led, num_data        : registered board outputs
//     switch               : asynchronous board switches (synchronised here)
module mmio_sram_responder
  import mmio_sram_responder_pkg::*;
#(
  parameter logic [15:0] BASE_HI = MMIO_BASE_HI,
  parameter int          LED_W   = 16,
  parameter int          SW_W    = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             sram_en,
  input  logic [3:0]       sram_we,
  input  logic [31:0]      sram_addr,
  input  logic [31:0]      sram_wdata,
  output logic [31:0]      sram_rdata,
  output logic [LED_W-1:0] led,
  output logic [31:0]      num_data,
  input  logic [SW_W-1:0]  switch
);

  function automatic logic [31:0] byte_merge(input logic [31:0] old,
                                             input logic [31:0] wd,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  mmio_req_t         req;
  logic [3:0][31:0]  cr_q, cr_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic [31:0]       num_q, num_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       rd_mux;
  logic [SW_W-1:0]   sw_s1_q, sw_s2_q;
  logic [3:0]        tmr_we;
  logic [31:0]       tmr_val;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^sram_addr[1:0];

  always_comb begin
    req.hit = sram_en && (sram_addr[31:16] == BASE_HI);
    req.rd  = sram_en && (sram_we == 4'b0000);
    req.wr  = req.hit && (sram_we != 4'b0000);
    req.off = {sram_addr[15:2], 2'b00};
  end

  assign tmr_we = (req.wr && req.off == OFF_TIMER) ? sram_we : 4'b0000;

`ifdef MMIO_TIMER_EN
  mmio_timer u_timer (
    .clk     (clk),
    .resetn  (resetn),
    .we_i    (tmr_we),
    .wdata_i (sram_wdata),
    .value_o (tmr_val)
  );
`else
  logic unused_tmr;
  assign unused_tmr = ^{tmr_we, 1'b0};
  assign tmr_val    = '0;
`endif

  // Read mux; registers narrower than 32 bits are zero-extended.
  always_comb begin
    rd_mux = '0;
    case (req.off)
      OFF_CR0, OFF_CR1, OFF_CR2, OFF_CR3: rd_mux = cr_q[req.off[3:2]];
      OFF_TIMER:  rd_mux = tmr_val;
      OFF_LED:    rd_mux = 32'(led_q);
      OFF_SWITCH: rd_mux = 32'(sw_s2_q);
      OFF_NUM:    rd_mux = num_q;
      default:    rd_mux = '0;
    endcase
  end

  always_comb begin
    cr_d    = cr_q;
    led_d   = led_q;
    num_d   = num_q;
    rdata_d = rdata_q;
    // Miss reads return 0; write cycles and idle cycles hold rdata.
    if (req.rd) rdata_d = req.hit ? rd_mux : 32'h0;
    if (req.wr) begin
      case (req.off)
        OFF_CR0, OFF_CR1, OFF_CR2, OFF_CR3:
          cr_d[req.off[3:2]] = byte_merge(cr_q[req.off[3:2]], sram_wdata, sram_we);
        OFF_NUM: num_d = byte_merge(num_q, sram_wdata, sram_we);
        OFF_LED:
          for (int b = 0; b < LED_W; b++)
            if (sram_we[b/8]) led_d[b] = sram_wdata[b];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      cr_q    <= '0;
      led_q   <= '0;
      num_q   <= '0;
      rdata_q <= '0;
      sw_s1_q <= '0;
      sw_s2_q <= '0;
    end else begin
      cr_q    <= cr_d;
      led_q   <= led_d;
      num_q   <= num_d;
      rdata_q <= rdata_d;
      sw_s1_q <= switch;
      sw_s2_q <= sw_s1_q;
    end

  assign sram_rdata = rdata_q;
  assign led        = led_q;
  assign num_data   = num_q;

endmodule

// File: tb/tb_mmio_sram_responder.sv
module tb_mmio_sram_responder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic [15:0] led;
  logic [31:0] num_data;
  logic [7:0]  switch;

  int n_chk  = 0;
  int n_pass = 0;

`ifdef MMIO_TIMER_EN
  localparam bit TMR = 1'b1;
`else
  localparam bit TMR = 1'b0;
`endif

  mmio_sram_responder #(.BASE_HI(16'hbfaf), .LED_W(16), .SW_W(8)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .led        (led),
    .num_data   (num_data),
    .switch     (switch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Drive one request cycle, step past the capturing edge, sample #1 later.
  task automatic req(input logic en, input logic [3:0] we,
                     input logic [31:0] addr, input logic [31:0] wd);
    sram_en = en; sram_we = we; sram_addr = addr; sram_wdata = wd;
    @(posedge clk); #1;
    sram_en = 1'b0; sram_we = 4'b0;
  endtask

  task automatic rd(input logic [31:0] addr);
    req(1'b1, 4'b0000, addr, 32'h0);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wd);
    req(1'b1, we, addr, wd);
  endtask

  initial begin
    resetn = 1'b0; sram_en = 1'b0; sram_we = 4'b0;
    sram_addr = '0; sram_wdata = '0; switch = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdata", sram_rdata, 32'h0);
    chk("rst_led",   32'(led),   32'h0);
    chk("rst_num",   num_data,   32'h0);
    resetn = 1'b1;

    rd(32'hbfaf_0000);
    chk("cr0_rd0", sram_rdata, 32'h0);
    chk("led0",    32'(led),   32'h0);
    chk("num0",    num_data,   32'h0);

    // Scratch register byte-lane writes
    wr(32'hbfaf_0004, 4'b1111, 32'h1234_5678);
    wr(32'hbfaf_0004, 4'b0010, 32'h0000_ab00);
    rd(32'hbfaf_0004);
    chk("cr1_merge", sram_rdata, 32'h1234_ab78);
    wr(32'hbfb0_0004, 4'b1111, 32'hffff_ffff);        // miss write ignored
    chk("wr_hold", sram_rdata, 32'h1234_ab78);
    req(1'b0, 4'b0000, 32'hbfaf_000c, 32'h0);
    chk("idle_hold", sram_rdata, 32'h1234_ab78);
    rd(32'hbfaf_0007);                                // addr[1:0] ignored
    chk("cr1_miss_wr", sram_rdata, 32'h1234_ab78);
    wr(32'hbfaf_000c, 4'b1000, 32'hdead_beef);
    rd(32'hbfaf_000c);
    chk("cr3_byte3", sram_rdata, 32'hde00_0000);

    // LED, NUM, SWITCH write-ignore
    wr(32'hbfaf_f020, 4'b1111, 32'hffff_a5a5);
    chk("led_wr", 32'(led), 32'h0000_a5a5);
    rd(32'hbfaf_f020);
    chk("led_rd", sram_rdata, 32'h0000_a5a5);
    wr(32'hbfaf_f020, 4'b0010, 32'h0000_3c00);
    chk("led_byte1", 32'(led), 32'h0000_3ca5);
    wr(32'hbfaf_f030, 4'b1111, 32'hffff_ffff);
    rd(32'hbfaf_f030);
    chk("sw_ro", sram_rdata, 32'h0);
    wr(32'hbfaf_f050, 4'b1111, 32'hcafe_f00d);
    chk("num_wr", num_data, 32'hcafe_f00d);
    rd(32'hbfaf_f050);
    chk("num_rd", sram_rdata, 32'hcafe_f00d);

    // Switch synchroniser: new value visible to a read captured on the 3rd edge
    switch = 8'h3c;
    rd(32'hbfaf_f030);
    chk("sw_e1", sram_rdata, 32'h0);
    rd(32'hbfaf_f030);
    chk("sw_e2", sram_rdata, 32'h0);
    rd(32'hbfaf_f030);
    chk("sw_e3", sram_rdata, 32'h0000_003c);

    // Miss and unmapped reads return 0
    rd(32'hbfb0_0000);
    chk("miss_rd", sram_rdata, 32'h0);
    rd(32'hbfaf_f050);
    rd(32'hbfaf_0100);
    chk("unmapped_rd", sram_rdata, 32'h0);

    // Timer wrap
    wr(32'hbfaf_e000, 4'b1111, 32'hffff_fffe);
    req(1'b0, 4'b0000, 32'h0, 32'h0);
    rd(32'hbfaf_e000);
    chk("tmr_ffff", sram_rdata, TMR ? 32'hffff_ffff : 32'h0);
    rd(32'hbfaf_e000);
    chk("tmr_wrap", sram_rdata, 32'h0);

    // Reset asserted in the middle of a write request
    rd(32'hbfaf_0004);
    chk("pre_rst", sram_rdata, 32'h1234_ab78);
    sram_en = 1'b1; sram_we = 4'b1111; sram_addr = 32'hbfaf_f020; sram_wdata = 32'h0000_1111;
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_rdata", sram_rdata, 32'h0);
    chk("mid_rst_num",   num_data,   32'h0);
    sram_en = 1'b0; sram_we = 4'b0;
    @(posedge clk); #1;
    chk("mid_rst_led", 32'(led), 32'h0);
    resetn = 1'b1;
    rd(32'hbfaf_e000);
    chk("tmr_from0", sram_rdata, 32'h0);
    wr(32'hbfaf_e000, 4'b0001, 32'h0000_00aa);
    rd(32'hbfaf_e000);
    chk("tmr_partial", sram_rdata, TMR ? 32'h0000_00aa : 32'h0);
    rd(32'hbfaf_0004);
    chk("cr1_cleared", sram_rdata, 32'h0);
    rd(32'hbfaf_f030);
    chk("sw_kept", sram_rdata, 32'h0000_003c);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
